// File: rtl/proc_fetch_unit_pkg.sv
// Shared TinyRV1 constants and types used by the fetch unit and its queues.
package proc_fetch_unit_pkg;

    localparam logic [31:0] RV_RESET_PC      = 32'h0000_0000;
    localparam logic [31:0] RV_INST_INVALID  = 32'h0000_0000;
    localparam logic [31:0] RV_INST_BYTES    = 32'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + RV_INST_BYTES;
    endfunction

endpackage

// File: rtl/proc_fetch_queue.sv
// Circular FIFO with flush, full/empty flags and occupancy count.
module proc_fetch_queue #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enq,
    input  logic [WIDTH-1:0] i_enq_data,
    input  logic             i_deq,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_head];

    // A full queue still accepts a write when the head leaves in the same cycle.
    assign w_push = i_enq & (~o_full | i_deq) & ~i_flush;
    assign w_pop  = i_deq & ~o_empty & ~i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= ptr_inc(r_tail);
            if (w_pop)  r_head <= ptr_inc(r_head);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= i_enq_data;
    end

endmodule

// File: rtl/proc_fetch_reg_en.sv
// Register primitive with load enable and asynchronous active-low reset.
module proc_fetch_reg_en #(
    parameter int             W         = 32,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= RESET_VAL;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/proc_fetch_unit.sv
// Instruction fetch: issues sequential fetches, buffers responses for decode,
// and squashes in-flight fetches on redirect.
module proc_fetch_unit
    import proc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RV_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemreq_val,
    input  logic        imemreq_rdy,
    output logic [31:0] imemreq_addr,
    input  logic        imemresp_val,
    input  logic [31:0] imemresp_data,
    input  logic        redirect_val,
    input  logic [31:0] redirect_pc,
    output logic        f2d_val,
    input  logic        f2d_rdy,
    output logic [31:0] f2d_inst,
    output logic [31:0] f2d_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [31:0]      w_pc;
    logic [31:0]      w_pc_next;
    logic             w_pc_en;
    logic [CNT_W-1:0] w_outst;
    logic [CNT_W-1:0] w_outst_next;
    logic             w_outst_en;
    logic [CNT_W-1:0] w_drop;
    logic [CNT_W-1:0] w_drop_next;
    logic             w_drop_en;

    logic             w_fire;
    logic             w_resp;
    logic             w_keep;
    logic             w_f2d_fire;
    logic [SUM_W-1:0] w_used;

    logic [31:0]      w_pend_head;
    logic             w_pend_full;
    logic             w_pend_empty;
    logic [CNT_W-1:0] w_pend_count;
    fetch_entry_t     w_inst_head;
    fetch_entry_t     w_inst_in;
    logic             w_inst_full;
    logic             w_inst_empty;
    logic [CNT_W-1:0] w_inst_count;
    logic             w_unused_flags;

    assign w_unused_flags = &{1'b0, w_pend_full, w_pend_count, w_inst_full};

    // A response is only meaningful when a request is pending for it.
    assign w_resp     = imemresp_val & ~w_pend_empty;
    assign w_keep     = w_resp & (w_drop == '0) & ~redirect_val;
    assign w_f2d_fire = f2d_val & f2d_rdy;

    // Credit check: in-flight plus buffered, less what decode takes now, must leave room.
    assign w_used = SUM_W'(w_outst) + SUM_W'(w_inst_count) - SUM_W'(w_f2d_fire);
    assign imemreq_val  = rst & ~redirect_val & (w_used < SUM_W'(DEPTH));
    assign imemreq_addr = w_pc;
    assign w_fire       = imemreq_val & imemreq_rdy;

    assign w_pc_en   = redirect_val | w_fire;
    assign w_pc_next = redirect_val ? redirect_pc : next_seq_pc(w_pc);

    assign w_outst_en   = w_fire ^ w_resp;
    assign w_outst_next = w_fire ? (w_outst + CNT_W'(1)) : (w_outst - CNT_W'(1));

    always_comb begin
        w_drop_en   = 1'b0;
        w_drop_next = w_drop;
        if (redirect_val) begin
            w_drop_en   = 1'b1;
            w_drop_next = w_outst - CNT_W'(w_resp);
        end else if (w_resp && (w_drop != '0)) begin
            w_drop_en   = 1'b1;
            w_drop_next = w_drop - CNT_W'(1);
        end
    end

    proc_fetch_reg_en #(.W(32), .RESET_VAL(RESET_PC)) u_pc_reg (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_pc_en),
        .i_d   (w_pc_next),
        .o_q   (w_pc)
    );

    proc_fetch_reg_en #(.W(CNT_W), .RESET_VAL('0)) u_outst_reg (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_outst_en),
        .i_d   (w_outst_next),
        .o_q   (w_outst)
    );

    proc_fetch_reg_en #(.W(CNT_W), .RESET_VAL('0)) u_drop_reg (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_drop_en),
        .i_d   (w_drop_next),
        .o_q   (w_drop)
    );

    // Pending-PC queue is never flushed: squashed responses still pop it.
    proc_fetch_queue #(.WIDTH(32), .DEPTH(DEPTH)) u_pend_q (
        .clk        (clk),
        .rst_n      (rst),
        .i_enq      (w_fire),
        .i_enq_data (w_pc),
        .i_deq      (w_resp),
        .i_flush    (1'b0),
        .o_head     (w_pend_head),
        .o_full     (w_pend_full),
        .o_empty    (w_pend_empty),
        .o_count    (w_pend_count)
    );

    assign w_inst_in = '{inst: imemresp_data, pc: w_pend_head};

    proc_fetch_queue #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_q (
        .clk        (clk),
        .rst_n      (rst),
        .i_enq      (w_keep),
        .i_enq_data (w_inst_in),
        .i_deq      (w_f2d_fire),
        .i_flush    (redirect_val),
        .o_head     (w_inst_head),
        .o_full     (w_inst_full),
        .o_empty    (w_inst_empty),
        .o_count    (w_inst_count)
    );

    assign f2d_val  = ~w_inst_empty;
    assign f2d_inst = f2d_val ? w_inst_head.inst : RV_INST_INVALID;
    assign f2d_pc   = w_inst_head.pc;

endmodule

// File: tb/tb_proc_fetch_unit.sv
// Directed bench for proc_fetch_unit with a one-cycle in-order memory model.
module tb_proc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imemreq_val;
    logic        imemreq_rdy = 1'b1;
    logic [31:0] imemreq_addr;
    logic        imemresp_val = 1'b0;
    logic [31:0] imemresp_data = 32'h0;
    logic        redirect_val = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        f2d_val;
    logic        f2d_rdy = 1'b1;
    logic [31:0] f2d_inst;
    logic [31:0] f2d_pc;

    logic        w_imemreq_val;
    logic [31:0] w_imemreq_addr;
    logic        w_f2d_val;
    logic [31:0] w_f2d_inst;
    logic [31:0] w_f2d_pc;

    int          n_tot = 0;
    int          n_bad = 0;
    bit          hold = 1'b1;
    logic        rec_fire;
    logic [31:0] rec_addr;
    logic [31:0] mq [$];

    always #5 clk = ~clk;

    proc_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .imemreq_val   (imemreq_val),
        .imemreq_rdy   (imemreq_rdy),
        .imemreq_addr  (imemreq_addr),
        .imemresp_val  (imemresp_val),
        .imemresp_data (imemresp_data),
        .redirect_val  (redirect_val),
        .redirect_pc   (redirect_pc),
        .f2d_val       (f2d_val),
        .f2d_rdy       (f2d_rdy),
        .f2d_inst      (f2d_inst),
        .f2d_pc        (f2d_pc)
    );

    proc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk           (clk),
        .rst           (rst),
        .imemreq_val   (w_imemreq_val),
        .imemreq_rdy   (imemreq_rdy),
        .imemreq_addr  (w_imemreq_addr),
        .imemresp_val  (imemresp_val),
        .imemresp_data (imemresp_data),
        .redirect_val  (redirect_val),
        .redirect_pc   (redirect_pc),
        .f2d_val       (w_f2d_val),
        .f2d_rdy       (f2d_rdy),
        .f2d_inst      (w_f2d_inst),
        .f2d_pc        (w_f2d_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic look();
        #1;
    endtask

    // Advance one clock; memory answers requests fired last cycle unless held.
    task automatic cyc();
        rec_fire = imemreq_val & imemreq_rdy;
        rec_addr = imemreq_addr;
        @(posedge clk);
        #1;
        if (rec_fire) mq.push_back(rec_addr);
        imemresp_val = 1'b0;
        if (!hold && mq.size() > 0) begin
            imemresp_val  = 1'b1;
            imemresp_data = mem_word(mq.pop_front());
        end
    endtask

    task automatic do_reset(input bit h);
        rst          = 1'b0;
        redirect_val = 1'b0;
        f2d_rdy      = 1'b1;
        imemresp_val = 1'b0;
        mq.delete();
        repeat (2) @(posedge clk);
        #1;
        hold = h;
        rst  = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req_val",  32'(imemreq_val), 32'd0);
        chk("rst_f2d_val",  32'(f2d_val), 32'd0);
        chk("rst_f2d_inst", f2d_inst, 32'h0);
        chk("rst_addr",     imemreq_addr, 32'h0);
        chk("rst_w_addr",   w_imemreq_addr, 32'hFFFF_FFFC);

        // sequential stream, latency 1, decode always ready
        do_reset(1'b0);
        chk("t1_c0_val",  32'(imemreq_val), 32'd1);
        chk("t1_c0_addr", imemreq_addr, 32'h0);
        chk("wrap_c0",    w_imemreq_addr, 32'hFFFF_FFFC);
        cyc(); look();
        chk("t1_c1_addr", imemreq_addr, 32'h4);
        chk("t1_c1_f2d",  32'(f2d_val), 32'd0);
        chk("wrap_c1",    w_imemreq_addr, 32'h0);
        cyc(); look();
        chk("t1_c2_f2d",  32'(f2d_val), 32'd1);
        chk("t1_c2_pc",   f2d_pc, 32'h0);
        chk("t1_c2_inst", f2d_inst, 32'h13);
        chk("t1_c2_addr", imemreq_addr, 32'h8);
        cyc(); look();
        chk("t1_c3_pc",   f2d_pc, 32'h4);
        chk("t1_c3_inst", f2d_inst, 32'h17);
        cyc(); look();
        chk("t1_c4_pc",   f2d_pc, 32'h8);
        chk("t1_c4_inst", f2d_inst, 32'h1b);

        // decode stall fills the buffer and throttles requests
        do_reset(1'b0);
        f2d_rdy = 1'b0;
        look();
        cyc(); look();
        cyc(); look();
        chk("t2_c2_val", 32'(imemreq_val), 32'd0);
        chk("t2_c2_f2d", 32'(f2d_val), 32'd1);
        cyc(); look();
        chk("t2_c3_val", 32'(imemreq_val), 32'd0);
        cyc(); look();
        chk("t2_c4_val", 32'(imemreq_val), 32'd0);
        chk("t2_c4_pc",  f2d_pc, 32'h0);
        cyc();
        f2d_rdy = 1'b1;
        look();
        chk("t2_c5_pc",   f2d_pc, 32'h0);
        chk("t2_c5_val",  32'(imemreq_val), 32'd1);
        chk("t2_c5_addr", imemreq_addr, 32'h8);
        cyc(); look();
        chk("t2_c6_pc",   f2d_pc, 32'h4);
        chk("t2_c6_inst", f2d_inst, 32'h17);
        cyc(); look();
        chk("t2_c7_pc",   f2d_pc, 32'h8);
        chk("t2_c7_inst", f2d_inst, 32'h1b);

        // redirect with two requests in flight
        do_reset(1'b1);
        cyc(); look();
        cyc();
        redirect_val = 1'b1;
        redirect_pc  = 32'h100;
        look();
        chk("t3_c2_val", 32'(imemreq_val), 32'd0);
        hold = 1'b0;
        cyc();
        redirect_val = 1'b0;
        look();
        chk("t3_c3_val", 32'(imemreq_val), 32'd0);
        chk("t3_c3_f2d", 32'(f2d_val), 32'd0);
        cyc(); look();
        chk("t3_c4_val",  32'(imemreq_val), 32'd1);
        chk("t3_c4_addr", imemreq_addr, 32'h100);
        chk("t3_c4_f2d",  32'(f2d_val), 32'd0);
        cyc(); look();
        chk("t3_c5_f2d",  32'(f2d_val), 32'd0);
        cyc(); look();
        chk("t3_c6_f2d",  32'(f2d_val), 32'd1);
        chk("t3_c6_pc",   f2d_pc, 32'h100);
        chk("t3_c6_inst", f2d_inst, 32'h113);

        // response coincides with redirect
        do_reset(1'b1);
        cyc(); look();
        hold = 1'b0;
        cyc();
        redirect_val = 1'b1;
        redirect_pc  = 32'h100;
        look();
        chk("t4_c2_resp", 32'(imemresp_val), 32'd1);
        chk("t4_c2_val",  32'(imemreq_val), 32'd0);
        cyc();
        redirect_val = 1'b0;
        look();
        chk("t4_c3_drop", 32'(dut.w_drop), 32'd1);
        chk("t4_c3_val",  32'(imemreq_val), 32'd1);
        chk("t4_c3_addr", imemreq_addr, 32'h100);
        chk("t4_c3_f2d",  32'(f2d_val), 32'd0);
        cyc(); look();
        chk("t4_c4_f2d",  32'(f2d_val), 32'd0);
        cyc(); look();
        chk("t4_c5_f2d",  32'(f2d_val), 32'd1);
        chk("t4_c5_pc",   f2d_pc, 32'h100);
        chk("t4_c5_inst", f2d_inst, 32'h113);

        // asynchronous reset with requests outstanding
        do_reset(1'b1);
        cyc(); look();
        cyc(); look();
        rst  = 1'b0;
        hold = 1'b0;
        look();
        chk("t5_async_val",  32'(imemreq_val), 32'd0);
        chk("t5_async_addr", imemreq_addr, 32'h0);
        chk("t5_async_f2d",  32'(f2d_val), 32'd0);
        chk("t5_async_inst", f2d_inst, 32'h0);
        cyc(); look();
        cyc(); look();
        chk("t5_inrst_f2d", 32'(f2d_val), 32'd0);
        cyc();
        rst = 1'b1;
        look();
        chk("t5_c0_f2d",  32'(f2d_val), 32'd0);
        chk("t5_c0_addr", imemreq_addr, 32'h0);
        cyc(); look();
        chk("t5_c1_f2d",  32'(f2d_val), 32'd0);
        cyc(); look();
        chk("t5_c2_f2d",  32'(f2d_val), 32'd1);
        chk("t5_c2_pc",   f2d_pc, 32'h0);
        chk("t5_c2_inst", f2d_inst, 32'h13);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/proc_fetch_unit.md
PROC_FETCH_UNIT -- requirements
Module: proc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, sets the instruction buffer entries and the cap on in-flight requests plus buffered instructions.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 imemreq_val  output  1  fetch request valid.
REQ-006 imemreq_rdy  input  1  memory accepts the request.
REQ-007 imemreq_addr  output  32  fetch byte address.
REQ-008 imemresp_val  input  1  response valid; always accepted, in request order.
REQ-009 imemresp_data  input  32  fetched instruction word.
REQ-010 redirect_val  input  1  squash and refetch (jump/taken branch).
REQ-011 redirect_pc  input  32  new fetch address.
REQ-012 f2d_val  output  1  instruction valid toward decode.
REQ-013 f2d_rdy  input  1  decode accepts (deasserted on decode stall).
REQ-014 f2d_inst  output  32  instruction to decode.
REQ-015 f2d_pc  output  32  PC of f2d_inst.

Function
REQ-016 The unit SHALL hold a fetch PC register; a request fires when imemreq_val & imemreq_rdy, and the PC then advances by 4 with 32-bit wrap-around.
REQ-017 imemreq_addr SHALL equal the fetch PC whenever imemreq_val is high.
REQ-018 imemreq_val SHALL be high iff rst is deasserted, redirect_val is low, and (outstanding + occupancy - (f2d_val & f2d_rdy)) < DEPTH.
REQ-019 A pending-PC queue of DEPTH entries SHALL record the address of each fired request; a kept response pairs with the head PC.
REQ-020 The outstanding counter (0..DEPTH) SHALL increment on a fire, decrement on a response, and stay unchanged when both occur in the same cycle.
REQ-021 Kept responses SHALL enqueue {data, pc} into a DEPTH-entry FIFO; f2d_val equals FIFO non-empty, and f2d_inst/f2d_pc come from the FIFO head.
REQ-022 A dequeue SHALL occur iff f2d_val & f2d_rdy; enqueue and dequeue in the same cycle keep occupancy unchanged, including when the FIFO is full.
REQ-023 When f2d_val is low, f2d_inst SHALL be 32'h0, so decode treats it as invalid; f2d_pc is don't-care.
REQ-024 Minimum latency SHALL be: request fires in cycle t, response in t+1, f2d_val high in t+2.
REQ-025 With a one-cycle-latency memory and f2d_rdy held high, one instruction SHALL be delivered per cycle in steady state.
REQ-026 On redirect_val, at the next edge: PC <= redirect_pc, FIFO flushed, and drop counter <= outstanding minus any response arriving that cycle; redirect takes priority over every other event.
REQ-027 While the drop counter is nonzero, each response SHALL be discarded and decrement it; discarded responses also decrement outstanding and pop the pending-PC queue.
REQ-028 A redirect arriving while drop counter > 0 SHALL set it to the current outstanding minus any response arriving that cycle.
REQ-029 Overflow of the FIFO, pending-PC queue, or counters is a design error; the unit SHALL make it unreachable under REQ-018.

Reset
REQ-030 While rst is low: PC = RESET_PC, FIFO and pending queue empty, outstanding = 0, drop = 0, imemreq_val = 0, f2d_val = 0, f2d_inst = 0.
REQ-031 Reset asserted mid-operation SHALL abandon all in-flight requests; responses arriving during reset SHALL be ignored.
REQ-032 The first request SHALL be issued in the first cycle after rst deasserts.

Structure
REQ-033 RESET_PC default and the NOP/invalid encoding 32'h0 SHALL live in the shared TinyRV1 package.
REQ-034 The instruction FIFO SHALL be one sub-module, proc_fetch_queue, parameterised by width and depth, with full/empty flags; it is also reused for the pending-PC queue.
REQ-035 The PC and counter registers SHALL be built from the codebase register primitive with enable.

Verification
REQ-036 Reset release, memory returns 0x00000013 at latency 1, f2d_rdy=1 -> imemreq_addr 0x0,0x4,0x8 on consecutive cycles; f2d_val from cycle 2 with f2d_pc 0x0,0x4,0x8.
REQ-037 f2d_rdy=0 for 5 cycles -> FIFO fills to 2, imemreq_val drops, no data lost; on release f2d_pc continues 0x0,0x4,0x8 in order.
REQ-038 redirect_val with redirect_pc=0x100 while 2 requests are in flight -> both responses dropped, next request address 0x100, and the first f2d_pc after the redirect is 0x100.
REQ-039 Response arrives in the same cycle as the redirect, with 2 requests outstanding -> drop counter = 1, and only the post-redirect fetch reaches decode.
REQ-040 RESET_PC=0xFFFFFFFC -> fetch addresses 0xFFFFFFFC then 0x00000000.
REQ-041 rst pulsed low while 2 requests are outstanding -> all outputs at reset values asynchronously, and late responses never appear on f2d.
